fwd_ctrl: RTL and testbench

Forwarding and hazard controller for the 16-bit MIPS pipeline. It tracks destination registers of instructions in the EX and MEM stages and produces registered 2-bit select codes for the two EX-stage forwarding muxes (00 register-file value, 01 EX/MEM ALU result, 10 MEM/WB memory result). It also detects load-use hazards and stalls IF/ID for exactly one cycle while a bubble enters EX. It sits beside the ID/EX pipeline register and drives the select inputs of both operand forwarding muxes.

---
 rtl/fwd_pkg.sv | 32 +++
 rtl/fwd_sel.sv | 23 ++
 rtl/fwd_ctrl.sv | 117 +++++++++++
 tb/tb_fwd_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding/hazard controller.
// Optional statistics counters in fwd_ctrl are enabled by FWD_CTRL_STATS_EN.
`timescale 1ns/1ps
package fwd_pkg;

    // Register-index width: 8 architectural registers, r0 hardwired to zero
    localparam int REG_BITS = 3;

    // Forwarding mux select codes
    localparam logic [1:0] FWD_BASE = 2'b00;
    localparam logic [1:0] FWD_ALU  = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    // One tracked pipeline slot (EX or MEM)
    typedef struct packed {
        logic                valid;
        logic [REG_BITS-1:0] dest;
        logic                wr;
        logic                load;
    } entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    // A slot only produces a forwardable value if it really writes a non-zero register
    function automatic logic is_producer(input entry_t e);
        return e.valid && e.wr && (e.dest != '0);
    endfunction

endpackage

// File: rtl/fwd_sel.sv
// Forwarding select for one source operand: EX (newest) beats MEM, else register file.
`timescale 1ns/1ps
module fwd_sel
    import fwd_pkg::*;
(
    input  logic [REG_BITS-1:0] src,
    input  logic                use_src,
    input  entry_t              ex,
    input  entry_t              mem,
    output logic [1:0]          sel
);

    // Priority compare of the source index against the two in-flight producers
    always_comb begin
        sel = FWD_BASE;
        if (use_src && (src != '0) && is_producer(ex) && (src == ex.dest)) begin
            sel = FWD_ALU;
        end else if (use_src && (src != '0) && is_producer(mem) && (src == mem.dest)) begin
            sel = FWD_MEM;
        end
    end

endmodule

// File: rtl/fwd_ctrl.sv
// Forwarding and load-use hazard controller for the 16-bit MIPS pipeline.
// Define FWD_CTRL_STATS_EN to add saturating stat_fwd / stat_stall counters.
`timescale 1ns/1ps
module fwd_ctrl
    import fwd_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    input  logic [REG_BITS-1:0] id_rs,
    input  logic [REG_BITS-1:0] id_rt,
    input  logic                id_use_rs,
    input  logic                id_use_rt,
    input  logic [REG_BITS-1:0] id_dest,
    input  logic                id_wr,
    input  logic                id_load,
    input  logic                hold,
    input  logic                flush,
    output logic                stall,
    output logic [1:0]          fwd_a,
`ifdef FWD_CTRL_STATS_EN
    output logic [15:0]         stat_fwd,
    output logic [15:0]         stat_stall,
`endif
    output logic [1:0]          fwd_b
);

    entry_t     ex_q;
    entry_t     mem_q;
    entry_t     id_entry;
    state_t     state_q;
    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic       haz;

    fwd_sel u_sel_rs (
        .src     (id_rs),
        .use_src (id_use_rs),
        .ex      (ex_q),
        .mem     (mem_q),
        .sel     (sel_a)
    );

    fwd_sel u_sel_rt (
        .src     (id_rt),
        .use_src (id_use_rt),
        .ex      (ex_q),
        .mem     (mem_q),
        .sel     (sel_b)
    );

    // Load in EX feeding the ID instruction; hold deliberately not part of this path
    always_comb begin
        haz = id_valid && !flush && (state_q == RUN) && is_producer(ex_q) && ex_q.load &&
              ((id_use_rs && (id_rs == ex_q.dest)) || (id_use_rt && (id_rt == ex_q.dest)));
        id_entry.valid = id_valid;
        id_entry.dest  = id_dest;
        id_entry.wr    = id_wr;
        id_entry.load  = id_load;
    end

    assign stall = haz;

    // Pipeline slot tracking, registered selects and the RUN/STALL machine
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q    <= '0;
            mem_q   <= '0;
            fwd_a   <= FWD_BASE;
            fwd_b   <= FWD_BASE;
            state_q <= RUN;
        end else if (hold) begin
            ex_q    <= ex_q;
            mem_q   <= mem_q;
            fwd_a   <= fwd_a;
            fwd_b   <= fwd_b;
            state_q <= state_q;
        end else if (flush) begin
            mem_q   <= ex_q;
            ex_q    <= '0;
            fwd_a   <= FWD_BASE;
            fwd_b   <= FWD_BASE;
            state_q <= RUN;
        end else if (haz) begin
            mem_q   <= ex_q;
            ex_q    <= '0;
            fwd_a   <= FWD_BASE;
            fwd_b   <= FWD_BASE;
            state_q <= STALL;
        end else begin
            mem_q   <= ex_q;
            ex_q    <= id_entry;
            fwd_a   <= sel_a;
            fwd_b   <= sel_b;
            state_q <= RUN;
        end
    end

`ifdef FWD_CTRL_STATS_EN
    // Saturating event counters: non-zero select loads and stall edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_fwd   <= '0;
            stat_stall <= '0;
        end else if (!hold) begin
            if (!flush && !haz && ((sel_a != FWD_BASE) || (sel_b != FWD_BASE)) &&
                (stat_fwd != 16'hFFFF)) begin
                stat_fwd <= stat_fwd + 16'd1;
            end
            if (haz && (stat_stall != 16'hFFFF)) begin
                stat_stall <= stat_stall + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fwd_ctrl.sv
// Self-checking bench for fwd_ctrl: directed scenarios followed by random traffic,
// all compared against an instruction-level reference model.
`timescale 1ns/1ps
module tb_fwd_ctrl;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [2:0] id_rs;
    logic [2:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic [2:0] id_dest;
    logic       id_wr;
    logic       id_load;
    logic       hold;
    logic       flush;
    logic       stall;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    int checks = 0;
    int errors = 0;

    // Reference model: the two most recent instructions that left ID
    typedef struct {
        bit valid;
        int dest;
        bit wr;
        bit load;
    } instr_t;

    instr_t m_ex;
    instr_t m_mem;
    bit     m_retry;
    int     m_fa;
    int     m_fb;

    fwd_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .id_valid  (id_valid),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .id_use_rs (id_use_rs),
        .id_use_rt (id_use_rt),
        .id_dest   (id_dest),
        .id_wr     (id_wr),
        .id_load   (id_load),
        .hold      (hold),
        .flush     (flush),
        .stall     (stall),
        .fwd_a     (fwd_a),
        .fwd_b     (fwd_b)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit writes_reg(input instr_t i);
        return i.valid && i.wr && (i.dest != 0);
    endfunction

    function automatic int source_of(input bit used, input int r);
        if (!used || r == 0) return 0;
        if (writes_reg(m_ex) && m_ex.dest == r) return 1;
        if (writes_reg(m_mem) && m_mem.dest == r) return 2;
        return 0;
    endfunction

    function automatic bit model_stall();
        if (!id_valid || flush || m_retry) return 1'b0;
        if (!writes_reg(m_ex) || !m_ex.load) return 1'b0;
        return (id_use_rs && int'(id_rs) == m_ex.dest) || (id_use_rt && int'(id_rt) == m_ex.dest);
    endfunction

    task automatic model_reset();
        m_ex    = '{0, 0, 0, 0};
        m_mem   = '{0, 0, 0, 0};
        m_retry = 1'b0;
        m_fa    = 0;
        m_fb    = 0;
    endtask

    task automatic model_edge(input bit stl);
        instr_t bubble;
        instr_t incoming;
        bubble   = '{0, 0, 0, 0};
        incoming = '{id_valid, int'(id_dest), id_wr, id_load};
        if (hold) return;
        if (flush || stl) begin
            m_mem   = m_ex;
            m_ex    = bubble;
            m_fa    = 0;
            m_fb    = 0;
            m_retry = stl;
        end else begin
            m_fa    = source_of(id_use_rs, int'(id_rs));
            m_fb    = source_of(id_use_rt, int'(id_rt));
            m_mem   = m_ex;
            m_ex    = incoming;
            m_retry = 1'b0;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] rs, input logic [2:0] rt,
                                 input logic urs, input logic urt, input logic [2:0] dst,
                                 input logic wr, input logic ld, input logic hd, input logic fl);
        id_valid  = v;
        id_rs     = rs;
        id_rt     = rt;
        id_use_rs = urs;
        id_use_rt = urt;
        id_dest   = dst;
        id_wr     = wr;
        id_load   = ld;
        hold      = hd;
        flush     = fl;
    endtask

    // One pipeline cycle: drive ID, check stall, clock, check registered selects
    task automatic step(input logic v, input logic [2:0] rs, input logic [2:0] rt,
                        input logic urs, input logic urt, input logic [2:0] dst,
                        input logic wr, input logic ld, input logic hd, input logic fl);
        bit exp_stall;
        applyStimulus(v, rs, rt, urs, urt, dst, wr, ld, hd, fl);
        #1;
        exp_stall = model_stall();
        checkOutput("stall", {15'd0, stall}, {15'd0, exp_stall});
        model_edge(exp_stall);
        @(posedge clk);
        #1;
        checkOutput("fwd_a", {14'd0, fwd_a}, 16'(m_fa));
        checkOutput("fwd_b", {14'd0, fwd_b}, 16'(m_fb));
    endtask

    // Directed scenarios, a mid-stall reset, then random traffic
    initial begin
        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #12;
        checkOutput("reset_fwd_a", {14'd0, fwd_a}, 16'd0);
        checkOutput("reset_fwd_b", {14'd0, fwd_b}, 16'd0);
        checkOutput("reset_stall", {15'd0, stall}, 16'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ALU to ALU: add r2,r1,r1 ; add r3,r2,r1
        step(1, 1, 1, 1, 1, 2, 1, 0, 0, 0);
        step(1, 2, 1, 1, 1, 3, 1, 0, 0, 0);
        checkOutput("alu_alu_a", {14'd0, fwd_a}, 16'd1);
        checkOutput("alu_alu_b", {14'd0, fwd_b}, 16'd0);

        // Distance two: write r4, independent op, read r4 on rt
        step(1, 1, 1, 1, 1, 4, 1, 0, 0, 0);
        step(1, 1, 1, 1, 1, 6, 1, 0, 0, 0);
        step(1, 1, 4, 1, 1, 7, 1, 0, 0, 0);
        checkOutput("dist2_b", {14'd0, fwd_b}, 16'd2);

        // Load-use: lw r5 ; add r6,r5,r5 (stalls once, then forwards from memory)
        step(1, 1, 0, 1, 0, 5, 1, 1, 0, 0);
        step(1, 5, 5, 1, 1, 6, 1, 0, 0, 0);
        checkOutput("lu_bubble_a", {14'd0, fwd_a}, 16'd0);
        step(1, 5, 5, 1, 1, 6, 1, 0, 0, 0);
        checkOutput("lu_retry_a", {14'd0, fwd_a}, 16'd2);
        checkOutput("lu_retry_b", {14'd0, fwd_b}, 16'd2);

        // r0 never forwards; r3 in both EX and MEM picks EX
        step(1, 1, 1, 1, 1, 0, 1, 0, 0, 0);
        step(1, 0, 0, 1, 1, 1, 0, 0, 0, 0);
        checkOutput("r0_a", {14'd0, fwd_a}, 16'd0);
        step(1, 1, 1, 1, 1, 3, 1, 0, 0, 0);
        step(1, 1, 1, 1, 1, 3, 1, 0, 0, 0);
        step(1, 3, 1, 1, 0, 4, 1, 0, 0, 0);
        checkOutput("prio_a", {14'd0, fwd_a}, 16'd1);

        // Hold during a load-use stall keeps everything frozen
        step(1, 1, 1, 1, 1, 2, 1, 1, 0, 0);
        step(1, 2, 1, 1, 1, 3, 1, 0, 1, 0);
        step(1, 2, 1, 1, 1, 3, 1, 0, 1, 0);
        step(1, 2, 1, 1, 1, 3, 1, 0, 0, 0);
        step(1, 2, 1, 1, 1, 3, 1, 0, 0, 0);
        checkOutput("hold_retry_a", {14'd0, fwd_a}, 16'd2);

        // Flush alongside a hazard: no stall, bubble, then the load is in MEM
        step(1, 1, 1, 1, 1, 7, 1, 1, 0, 0);
        step(1, 7, 7, 1, 1, 1, 1, 0, 0, 1);
        checkOutput("flush_a", {14'd0, fwd_a}, 16'd0);
        step(1, 7, 1, 1, 1, 1, 1, 0, 0, 0);
        checkOutput("post_flush_a", {14'd0, fwd_a}, 16'd2);

        // Reset while a stall is pending
        step(1, 2, 2, 1, 1, 1, 1, 1, 0, 0);
        applyStimulus(1, 1, 1, 1, 1, 2, 1, 0, 0, 0);
        #1;
        checkOutput("pre_reset_stall", {15'd0, stall}, {15'd0, model_stall()});
        rst_n = 1'b0;
        #1;
        checkOutput("mid_reset_stall", {15'd0, stall}, 16'd0);
        checkOutput("mid_reset_fwd_a", {14'd0, fwd_a}, 16'd0);
        model_reset();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Random traffic with a narrow register range to provoke dependencies
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 9) != 0,
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 1'($urandom), 1'($urandom),
                 3'($urandom_range(0, 7)),
                 $urandom_range(0, 4) != 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
